// File: rtl/full_adder_behavioral_pkg.sv
// Shared constants for the registered ripple adder.
package full_adder_behavioral_pkg;
  localparam int MAX_WIDTH = 64;
  localparam int STAGES    = 1;
endpackage

// File: rtl/full_adder_cell.sv
// 1-bit combinational full-adder cell; one link of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/full_adder_behavioral.sv
// Width-parameterised ripple-carry adder with one registered output stage
// carrying sum, carry-out, signed overflow and a valid flag.
module full_adder_behavioral
  import full_adder_behavioral_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] X2,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic [STAGES:0]  vld_pipe;

  assign c[0] = Cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a  (X1[i]),
        .b  (X2[i]),
        .ci (c[i]),
        .s  (sum[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  // Data registers are enabled by in_valid only, so invalid cycles hold them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S                   <= '0;
      Cout                <= 1'b0;
      ovf                 <= 1'b0;
      vld_pipe[STAGES:1]  <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (in_valid) begin
        S    <= sum;
        Cout <= c[WIDTH];
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_full_adder_behavioral.sv
// Directed bench for a 1-bit and an 8-bit instance sharing clock and reset.
module tb_full_adder_behavioral;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       a1, b1, ci1;
  logic [7:0] a8, b8;
  logic       ci8;

  logic       s1, co1, ovf1, ov1;
  logic [7:0] s8;
  logic       co8, ovf8, ov8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder_behavioral #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .X1(a1), .X2(b1), .Cin(ci1),
    .S(s1), .Cout(co1), .ovf(ovf1), .out_valid(ov1)
  );

  full_adder_behavioral #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .X1(a8), .X2(b8), .Cin(ci8),
    .S(s8), .Cout(co8), .ovf(ovf8), .out_valid(ov8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    tick();
    n_checks++;
    if ({co1, s1, ovf1, ov1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_w1: got {Cout,S,ovf,out_valid}=%b expected 0000", {co1, s1, ovf1, ov1});
    end
    n_checks++;
    if ({co8, s8, ovf8, ov8} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_w8: got Cout=%b S=%h ovf=%b out_valid=%b expected all 0", co8, s8, ovf8, ov8);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] v;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, ci1} = v;
      tick();
      n_checks++;
      if ({co1, s1} !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL w1_sum[%0d]: got {Cout,S}=%b expected %b", i, {co1, s1}, exp_tab[i]);
      end
      n_checks++;
      if (ovf1 !== (ci1 ^ exp_tab[i][1])) begin
        n_fail++;
        $display("FAIL w1_ovf[%0d]: got %b expected %b", i, ovf1, ci1 ^ exp_tab[i][1]);
      end
      n_checks++;
      if (ov1 !== 1'b1) begin
        n_fail++;
        $display("FAIL w1_out_valid[%0d]: got %b expected 1", i, ov1);
      end
    end
  endtask

  task automatic test_boundaries_w8();
    logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h80};
    logic [7:0] vb [3] = '{8'hFF, 8'h01, 8'h80};
    logic       vc [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] es [3] = '{8'hFF, 8'h80, 8'h00};
    logic       ec [3] = '{1'b1, 1'b0, 1'b1};
    logic       eo [3] = '{1'b0, 1'b1, 1'b1};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; ci8 = vc[i];
      tick();
      n_checks++;
      if ({co8, s8, ovf8} !== {ec[i], es[i], eo[i]}) begin
        n_fail++;
        $display("FAIL w8_boundary[%0d]: got Cout=%b S=%h ovf=%b expected Cout=%b S=%h ovf=%b",
                 i, co8, s8, ovf8, ec[i], es[i], eo[i]);
      end
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
    tick();
    n_checks++;
    if ({co8, s8, ov8} !== {1'b0, 8'h46, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_capture: got Cout=%b S=%h out_valid=%b expected 0 46 1", co8, s8, ov8);
    end
    in_valid = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    tick();
    n_checks++;
    if ({co8, s8, ovf8, ov8} !== {1'b0, 8'h46, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_invalid: got Cout=%b S=%h ovf=%b out_valid=%b expected 0 46 0 0", co8, s8, ovf8, ov8);
    end
    tick();
    n_checks++;
    if ({s8, ov8} !== {8'h46, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_second: got S=%h out_valid=%b expected 46 0", s8, ov8);
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0;
    tick();
    rst_n = 1'b0; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0;
    tick();
    n_checks++;
    if ({co8, s8, ovf8, ov8} !== 11'h000) begin
      n_fail++;
      $display("FAIL mid_reset: got Cout=%b S=%h ovf=%b out_valid=%b expected all 0", co8, s8, ovf8, ov8);
    end
    rst_n = 1'b1; a8 = 8'h03; b8 = 8'h04; ci8 = 1'b1;
    tick();
    n_checks++;
    if ({co8, s8, ov8} !== {1'b0, 8'h08, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset: got Cout=%b S=%h out_valid=%b expected 0 08 1", co8, s8, ov8);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ref_sum;
    logic       ref_ovf;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      ref_sum = {1'b0, a8} + {1'b0, b8} + {8'h00, ci8};
      ref_ovf = (a8[7] == b8[7]) && (ref_sum[7] != a8[7]);
      tick();
      n_checks++;
      if ({co8, s8, ovf8, ov8} !== {ref_sum, ref_ovf, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: %h+%h+%b got Cout=%b S=%h ovf=%b out_valid=%b expected %b %h %b 1",
                 i, a8, b8, ci8, co8, s8, ovf8, ov8, ref_sum[8], ref_sum[7:0], ref_ovf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    tick();
    test_reset();
    test_exhaustive_w1();
    test_boundaries_w8();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
